snoop_responder: RTL and testbench

- Peer-side coherence agent. It answers the inter-cache message interface that an MSI cache drives: havMsgToCache, rmToCache, wmToCache, invToCache, addrToCache and allowReadFromCache.
- It keeps a direct-mapped MSI shadow of the local cache's tags, states and data.
- It writes Modified lines back to the memory bus when a peer snoops them, then releases the initiator through allowRead.
- It downgrades or invalidates local lines and reports each change to the local cache.

---
 rtl/snoop_responder.sv | 168 ++++++++++++++++
 tb/tb_snoop_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/snoop_responder.sv
// Peer-side MSI snoop responder: shadows the local cache's lines, writes back
// Modified data when a peer snoops it, and reports downgrades/invalidations.
module snoop_responder #(
  parameter int ADDR_W     = 8,
  parameter int WORD_W     = 16,
  parameter int IDX_W      = 2,
  parameter int WB_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              havMsg,
  input  logic              rm,
  input  logic              wm,
  input  logic              inv,
  input  logic [ADDR_W-1:0] addr,
  output logic              allowRead,
  output logic [1:0]        rwToMem,
  output logic [ADDR_W-1:0] addrToMem,
  output logic [WORD_W-1:0] dataToMem,
  input  logic              writeDoneFromMem,
  input  logic              fillEn,
  input  logic [ADDR_W-1:0] fillAddr,
  input  logic [1:0]        fillState,
  input  logic [WORD_W-1:0] fillData,
  output logic              fillReady,
  output logic              invToLocal,
  output logic              downgradeToLocal,
  output logic [ADDR_W-1:0] localAddr,
  output logic              protoErr
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int CNT_W = $clog2(WB_TIMEOUT + 1);
  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, DONE} state_t;

  state_t state_q, state_d;
  logic rm_q, rm_d, wm_q, wm_d, inv_q, inv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] post_q, post_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic allow_q, allow_d, fready_q, fready_d;
  logic [1:0] rw_q, rw_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d, laddr_q, laddr_d;
  logic [WORD_W-1:0] mdata_q, mdata_d;
  logic ipulse_q, ipulse_d, dg_q, dg_d, perr_q, perr_d;

  logic [1:0]        st_q  [LINES];
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [WORD_W-1:0] dat_q [LINES];

  logic fill_we, st_we;
  logic [1:0] st_wval;
  logic [IDX_W-1:0] idx_l, idx_f;
  logic hit;

  assign idx_l = addr_q[IDX_W-1:0];
  assign idx_f = fillAddr[IDX_W-1:0];
  assign hit   = (st_q[idx_l] != ST_I) && (tag_q[idx_l] == addr_q[ADDR_W-1:IDX_W]);

  always_comb begin
    state_d = state_q;
    rm_d = rm_q; wm_d = wm_q; inv_d = inv_q; addr_d = addr_q;
    post_d = post_q; cnt_d = cnt_q;
    allow_d = allow_q; rw_d = rw_q;
    maddr_d = maddr_q; mdata_d = mdata_q; laddr_d = laddr_q;
    ipulse_d = 1'b0; dg_d = 1'b0; perr_d = perr_q;
    fill_we = 1'b0; st_we = 1'b0; st_wval = ST_I;
    case (state_q)
      IDLE: begin
        fill_we = fillEn && fready_q;
        if (havMsg) begin
          rm_d = rm; wm_d = wm; inv_d = inv; addr_d = addr;
          allow_d = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = DONE;
        allow_d = 1'b1;
        if (!$onehot({rm_q, wm_q, inv_q})) begin
          perr_d = 1'b1;
        end else if ((rm_q || wm_q) && hit && st_q[idx_l] == ST_M) begin
          state_d = WB;
          allow_d = 1'b0;
          rw_d    = 2'b10;
          maddr_d = addr_q;
          mdata_d = dat_q[idx_l];
          cnt_d   = '0;
          post_d  = rm_q ? ST_S : ST_I;
        end else if ((wm_q || inv_q) && hit) begin
          // Shared line hit by wm/inv, or Modified hit by inv (illegal: dropped without writeback)
          st_we    = 1'b1;
          ipulse_d = 1'b1;
          laddr_d  = addr_q;
          if (st_q[idx_l] == ST_M) perr_d = 1'b1;
        end
      end
      WB: begin
        if (writeDoneFromMem) begin
          st_we    = 1'b1;
          st_wval  = post_q;
          dg_d     = (post_q == ST_S);
          ipulse_d = (post_q != ST_S);
          laddr_d  = addr_q;
          rw_d     = 2'b00;
          allow_d  = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rw_d    = 2'b00;
          perr_d  = 1'b1;
          allow_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!havMsg) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    fready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rm_q <= 1'b0; wm_q <= 1'b0; inv_q <= 1'b0; addr_q <= '0;
      post_q <= ST_I; cnt_q <= '0;
      allow_q <= 1'b1; fready_q <= 1'b1; rw_q <= 2'b00;
      maddr_q <= '0; mdata_q <= '0; laddr_q <= '0;
      ipulse_q <= 1'b0; dg_q <= 1'b0; perr_q <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        st_q[i]  <= ST_I;
        tag_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rm_q <= rm_d; wm_q <= wm_d; inv_q <= inv_d; addr_q <= addr_d;
      post_q <= post_d; cnt_q <= cnt_d;
      allow_q <= allow_d; fready_q <= fready_d; rw_q <= rw_d;
      maddr_q <= maddr_d; mdata_q <= mdata_d; laddr_q <= laddr_d;
      ipulse_q <= ipulse_d; dg_q <= dg_d; perr_q <= perr_d;
      if (fill_we) begin
        st_q[idx_f]  <= fillState;
        tag_q[idx_f] <= fillAddr[ADDR_W-1:IDX_W];
        dat_q[idx_f] <= fillData;
      end
      if (st_we) st_q[idx_l] <= st_wval;
    end
  end

  assign allowRead        = allow_q;
  assign rwToMem          = rw_q;
  assign addrToMem        = maddr_q;
  assign dataToMem        = mdata_q;
  assign fillReady        = fready_q;
  assign invToLocal       = ipulse_q;
  assign downgradeToLocal = dg_q;
  assign localAddr        = laddr_q;
  assign protoErr         = perr_q;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: a vector table of fill+snoop transactions
// followed by hand-written timeout and reset-during-writeback sequences.
module tb_snoop_responder;

  logic        clk = 1'b0;
  logic        reset, havMsg, rm, wm, inv, writeDoneFromMem, fillEn;
  logic [7:0]  addr, fillAddr, addrToMem, localAddr;
  logic [1:0]  fillState, rwToMem;
  logic [15:0] fillData, dataToMem;
  logic        allowRead, fillReady, invToLocal, downgradeToLocal, protoErr;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] S = 2'b01, M = 2'b10;

  snoop_responder dut (
    .clk(clk), .reset(reset), .havMsg(havMsg), .rm(rm), .wm(wm), .inv(inv),
    .addr(addr), .allowRead(allowRead), .rwToMem(rwToMem), .addrToMem(addrToMem),
    .dataToMem(dataToMem), .writeDoneFromMem(writeDoneFromMem), .fillEn(fillEn),
    .fillAddr(fillAddr), .fillState(fillState), .fillData(fillData),
    .fillReady(fillReady), .invToLocal(invToLocal), .downgradeToLocal(downgradeToLocal),
    .localAddr(localAddr), .protoErr(protoErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_fill;
    logic [7:0]  faddr;
    logic [1:0]  fst;
    logic [15:0] fdata;
    logic [2:0]  op;        // {rm, wm, inv}
    logic [7:0]  addr;
    int          done_dly;  // WB cycles before writeDone; 0 = never
    int          exp_low;
    int          exp_wb;
    logic [15:0] exp_data;
    int          exp_inv;
    int          exp_dg;
    logic [7:0]  exp_paddr;
    logic        exp_perr;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(bit f, logic [7:0] fa, logic [1:0] fs, logic [15:0] fd,
                              logic [2:0] op, logic [7:0] a, int d, int low, int wb,
                              logic [15:0] ed, int ei, int edg, logic [7:0] pa, logic pe);
    vec_t t;
    t.do_fill = f; t.faddr = fa; t.fst = fs; t.fdata = fd; t.op = op; t.addr = a;
    t.done_dly = d; t.exp_low = low; t.exp_wb = wb; t.exp_data = ed;
    t.exp_inv = ei; t.exp_dg = edg; t.exp_paddr = pa; t.exp_perr = pe;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called and returns at a negedge.
  task automatic do_fill(input logic [7:0] a, input logic [1:0] st, input logic [15:0] d);
    fillEn = 1'b1; fillAddr = a; fillState = st; fillData = d;
    @(negedge clk);
    fillEn = 1'b0;
  endtask

  task automatic run_txn(input vec_t t, input string nm);
    int low = 0, wbc = 0, invc = 0, dgc = 0, both = 0, badrw = 0, post = 0;
    logic [7:0]  wba = '0, pa = '0;
    logic [15:0] wbd = '0;
    bit released = 0;
    if (t.do_fill) do_fill(t.faddr, t.fst, t.fdata);
    havMsg = 1'b1; {rm, wm, inv} = t.op; addr = t.addr;
    for (int cyc = 0; cyc < 400 && post < 3; cyc++) begin
      @(negedge clk);
      if (!allowRead) low++;
      if (rwToMem == 2'b10) begin wbc++; wba = addrToMem; wbd = dataToMem; end
      else if (rwToMem != 2'b00) badrw++;
      if (invToLocal) begin invc++; pa = localAddr; end
      if (downgradeToLocal) begin dgc++; pa = localAddr; end
      if (invToLocal && downgradeToLocal) both++;
      writeDoneFromMem = (rwToMem == 2'b10) && (t.done_dly != 0) && (wbc == t.done_dly);
      if (released) post++;
      else if (allowRead && low > 0) begin
        havMsg = 1'b0; {rm, wm, inv} = 3'b000; released = 1;
      end
    end
    havMsg = 1'b0; {rm, wm, inv} = 3'b000; writeDoneFromMem = 1'b0;
    chk($sformatf("%s completed", nm), 32'(released), 32'd1);
    chk($sformatf("%s allowRead-low cycles", nm), low, t.exp_low);
    chk($sformatf("%s wb cycles", nm), wbc, t.exp_wb);
    if (t.exp_wb > 0) begin
      chk($sformatf("%s wb addr", nm), wba, t.addr);
      chk($sformatf("%s wb data", nm), wbd, t.exp_data);
    end
    chk($sformatf("%s inv pulses", nm), invc, t.exp_inv);
    chk($sformatf("%s dg pulses", nm), dgc, t.exp_dg);
    if (t.exp_inv + t.exp_dg > 0) chk($sformatf("%s localAddr", nm), pa, t.exp_paddr);
    chk($sformatf("%s both pulses", nm), both, 0);
    chk($sformatf("%s illegal rw code", nm), badrw, 0);
    chk($sformatf("%s protoErr", nm), protoErr, t.exp_perr);
    chk($sformatf("%s fillReady idle", nm), fillReady, 1'b1);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " allowRead"}, allowRead, 1'b1);
    chk({nm, " rwToMem"}, rwToMem, 2'b00);
    chk({nm, " protoErr"}, protoErr, 1'b0);
    chk({nm, " fillReady"}, fillReady, 1'b1);
    chk({nm, " pulses"}, {invToLocal, downgradeToLocal}, 2'b00);
  endtask

  initial begin
    reset = 1'b1; havMsg = 0; rm = 0; wm = 0; inv = 0; addr = '0;
    writeDoneFromMem = 0; fillEn = 0; fillAddr = '0; fillState = '0; fillData = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    chk("reset addrToMem", addrToMem, 8'h00);
    chk("reset dataToMem", dataToMem, 16'h0000);
    chk("reset localAddr", localAddr, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    tbl[0]  = mk(1, 8'h05, M, 16'h0003, 3'b100, 8'h05, 3, 4, 3, 16'h0003, 0, 1, 8'h05, 0);
    tbl[1]  = mk(0, 8'h00, 0, 16'h0000, 3'b010, 8'h05, 0, 1, 0, 16'h0000, 1, 0, 8'h05, 0);
    tbl[2]  = mk(1, 8'h06, S, 16'h1111, 3'b010, 8'h06, 0, 1, 0, 16'h0000, 1, 0, 8'h06, 0);
    tbl[3]  = mk(0, 8'h00, 0, 16'h0000, 3'b010, 8'h06, 0, 1, 0, 16'h0000, 0, 0, 8'h00, 0);
    tbl[4]  = mk(1, 8'h05, M, 16'h00A5, 3'b100, 8'h45, 0, 1, 0, 16'h0000, 0, 0, 8'h00, 0);
    tbl[5]  = mk(0, 8'h00, 0, 16'h0000, 3'b010, 8'h05, 2, 3, 2, 16'h00A5, 1, 0, 8'h05, 0);
    tbl[6]  = mk(1, 8'h0A, S, 16'h2222, 3'b001, 8'h0A, 0, 1, 0, 16'h0000, 1, 0, 8'h0A, 0);
    tbl[7]  = mk(1, 8'h0B, S, 16'h5555, 3'b100, 8'h0B, 0, 1, 0, 16'h0000, 0, 0, 8'h00, 0);
    tbl[8]  = mk(0, 8'h00, 0, 16'h0000, 3'b010, 8'h0B, 0, 1, 0, 16'h0000, 1, 0, 8'h0B, 0);
    tbl[9]  = mk(1, 8'h07, S, 16'h4444, 3'b110, 8'h07, 0, 1, 0, 16'h0000, 0, 0, 8'h00, 1);
    tbl[10] = mk(0, 8'h00, 0, 16'h0000, 3'b100, 8'h07, 0, 1, 0, 16'h0000, 0, 0, 8'h00, 1);
    tbl[11] = mk(0, 8'h00, 0, 16'h0000, 3'b010, 8'h07, 0, 1, 0, 16'h0000, 1, 0, 8'h07, 1);
    tbl[12] = mk(1, 8'h0C, M, 16'h3333, 3'b001, 8'h0C, 0, 1, 0, 16'h0000, 1, 0, 8'h0C, 1);
    tbl[13] = mk(0, 8'h00, 0, 16'h0000, 3'b010, 8'h0C, 0, 1, 0, 16'h0000, 0, 0, 8'h00, 1);
    tbl[14] = mk(1, 8'h0D, M, 16'hBEEF, 3'b100, 8'h0D, 1, 2, 1, 16'hBEEF, 0, 1, 8'h0D, 1);
    tbl[15] = mk(0, 8'h00, 0, 16'h0000, 3'b010, 8'h0D, 0, 1, 0, 16'h0000, 1, 0, 8'h0D, 1);

    for (int i = 0; i < 16; i++) run_txn(tbl[i], $sformatf("row%0d", i));

    // Writeback timeout: memory never answers, line stays Modified.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("reset2");
    reset = 1'b0;
    @(negedge clk);
    run_txn(mk(1, 8'h07, M, 16'h7777, 3'b010, 8'h07, 0, 256, 255, 16'h7777, 0, 0, 8'h00, 1), "timeout");
    run_txn(mk(0, 8'h00, 0, 16'h0000, 3'b100, 8'h07, 1, 2, 1, 16'h7777, 0, 1, 8'h07, 1), "after-timeout");

    // Reset in the middle of a writeback.
    do_fill(8'h05, M, 16'h1234);
    havMsg = 1'b1; rm = 1'b1; addr = 8'h05;
    for (int k = 0; k < 10 && rwToMem != 2'b10; k++) @(negedge clk);
    chk("rstwb wb entered", rwToMem, 2'b10);
    @(negedge clk);
    reset = 1'b1; havMsg = 1'b0; rm = 1'b0;
    @(negedge clk);
    chk_reset_state("rstwb");
    reset = 1'b0;
    do_fill(8'h05, M, 16'h5678);
    run_txn(mk(0, 8'h00, 0, 16'h0000, 3'b100, 8'h05, 1, 2, 1, 16'h5678, 0, 1, 8'h05, 0), "rstwb refill");
    run_txn(mk(0, 8'h00, 0, 16'h0000, 3'b010, 8'h07, 0, 1, 0, 16'h0000, 0, 0, 8'h00, 0), "rstwb cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
